pc_fetch_unit: RTL and testbench

- Consumes the next-PC address and the redirect decision produced by the ID-stage address mux.
- Owns the architectural PC register and issues instruction-memory requests over a req/ready handshake.
- Presents fetched instructions to IF/ID through a valid/ready output register backed by a one-entry skid buffer.
- Kills wrong-path work on redirect: it flushes the output register and discards any in-flight fetch.

---
 rtl/pc_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Instruction fetch stage. Owns the architectural PC, issues
//               instruction-memory requests over a req/ready handshake and
//               presents fetched words to IF/ID through a valid/ready output
//               register backed by a one-entry skid buffer. Redirects flush
//               the output path and discard any in-flight fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] next_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_ins_q, if_ins_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0] skid_ins_q, skid_ins_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] w_target;
    logic        w_load_ok;

    // Redirect targets are forced to word alignment; misalignment is flagged.
    assign w_target  = {next_addr[31:2], 2'b00};
    // Output register may accept a new word when empty or being drained.
    assign w_load_ok = !if_valid_q || if_ready;

    // Next-state and datapath updates; redirect takes priority in every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        if_valid_d    = if_valid_q;
        if_ins_d      = if_ins_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        skid_ins_d    = skid_ins_q;
        skid_pc_d     = skid_pc_q;
        addr_err_d    = addr_err_q;

        if (redirect) begin
            if_valid_d = 1'b0;
            skid_ins_d = 32'd0;
            skid_pc_d  = 32'd0;
            if (next_addr[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (redirect) begin
                    pc_d = w_target;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d = w_target;
                    end else begin
                        pending_d = w_target;
                        state_d   = ST_DROP;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_q + 32'd4;
                    if (w_load_ok) begin
                        if_valid_d    = 1'b1;
                        if_ins_d      = imem_rdata;
                        if_pc_d       = pc_q;
                        if_pc_plus4_d = pc_q + 32'd4;
                    end else begin
                        skid_ins_d = imem_rdata;
                        skid_pc_d  = pc_q;
                        state_d    = ST_HOLD;
                    end
                end else if (if_valid_q && if_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = w_target;
                    state_d = ST_FETCH;
                end else if (if_ready) begin
                    if_valid_d    = 1'b1;
                    if_ins_d      = skid_ins_q;
                    if_pc_d       = skid_pc_q;
                    if_pc_plus4_d = skid_pc_q + 32'd4;
                    state_d       = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d    = w_target;
                        state_d = ST_FETCH;
                    end else begin
                        pending_d = w_target;
                    end
                end else if (imem_ready) begin
                    pc_d    = pending_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            pending_q     <= 32'd0;
            if_valid_q    <= 1'b0;
            if_ins_q      <= NOP_INS;
            if_pc_q       <= 32'd0;
            if_pc_plus4_q <= 32'd4;
            skid_ins_q    <= 32'd0;
            skid_pc_q     <= 32'd0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            if_valid_q    <= if_valid_d;
            if_ins_q      <= if_ins_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            skid_ins_q    <= skid_ins_d;
            skid_pc_q     <= skid_pc_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // Request is held (address stable) in FETCH and while draining in DROP.
    assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DROP);
    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_ins      = if_valid_q ? if_ins_q : NOP_INS;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign addr_err    = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        redirect;
    logic [31:0] next_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        addr_err;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .NOP_INS  (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .next_addr   (next_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_ins      (if_ins),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .addr_err    (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory content: each word is its address XOR a fixed tag.
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        redirect   = 1'b0;
        next_addr  = 32'd0;
        imem_ready = 1'b1;
        if_ready   = 1'b1;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        reset_n = 1'b0;
        step();
        chk("rst_req",    {31'd0, imem_req},    32'd0);
        chk("rst_valid",  {31'd0, if_valid},    32'd0);
        chk("rst_ins",    if_ins,               32'h0000_0000);
        chk("rst_pc",     if_pc,                32'd0);
        chk("rst_pc4",    if_pc_plus4,          32'd4);
        chk("rst_err",    {31'd0, addr_err},    32'd0);
        chk("rst_addr",   imem_addr,            32'h0000_3000);
        reset_n = 1'b1;

        // ---------------- 1: back-to-back fetch ----------------
        chk("t1_boot_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("t1_req",      {31'd0, imem_req}, 32'd1);
        chk("t1_addr0",    imem_addr,         32'h0000_3000);
        chk("t1_valid0",   {31'd0, if_valid}, 32'd0);
        step();
        chk("t1_valid1",   {31'd0, if_valid}, 32'd1);
        chk("t1_pc1",      if_pc,             32'h0000_3000);
        chk("t1_ins1",     if_ins,            32'hA5A5_3000);
        chk("t1_pc4_1",    if_pc_plus4,       32'h0000_3004);
        step();
        chk("t1_pc2",      if_pc,             32'h0000_3004);
        chk("t1_pc4_2",    if_pc_plus4,       32'h0000_3008);
        chk("t1_valid2",   {31'd0, if_valid}, 32'd1);
        step();
        chk("t1_pc3",      if_pc,             32'h0000_3008);
        chk("t1_valid3",   {31'd0, if_valid}, 32'd1);

        // ---------------- 2: memory wait states ----------------
        do_reset();
        step();
        step();
        chk("t2_pc0",      if_pc,             32'h0000_3000);
        imem_ready = 1'b0;
        chk("t2_req_w0",   {31'd0, imem_req}, 32'd1);
        chk("t2_addr_w0",  imem_addr,         32'h0000_3004);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t2_req_w",   {31'd0, imem_req}, 32'd1);
            chk("t2_addr_w",  imem_addr,         32'h0000_3004);
            chk("t2_valid_w", {31'd0, if_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        step();
        chk("t2_valid",    {31'd0, if_valid}, 32'd1);
        chk("t2_pc1",      if_pc,             32'h0000_3004);
        chk("t2_ins1",     if_ins,            32'hA5A5_3004);
        step();
        chk("t2_pc2",      if_pc,             32'h0000_3008);

        // ---------------- 3: output stall into skid / HOLD ----------------
        do_reset();
        step();
        step();
        step();
        chk("t3_pc_pre",   if_pc,             32'h0000_3004);
        if_ready = 1'b0;
        step();
        chk("t3_hold_req", {31'd0, imem_req}, 32'd0);
        chk("t3_hold_pc",  if_pc,             32'h0000_3004);
        chk("t3_hold_vld", {31'd0, if_valid}, 32'd1);
        step();
        chk("t3_hold_req2", {31'd0, imem_req}, 32'd0);
        chk("t3_hold_pc2", if_pc,             32'h0000_3004);
        if_ready = 1'b1;
        step();
        chk("t3_skid_pc",  if_pc,             32'h0000_3008);
        chk("t3_skid_ins", if_ins,            32'hA5A5_3008);
        chk("t3_skid_pc4", if_pc_plus4,       32'h0000_300C);
        chk("t3_skid_vld", {31'd0, if_valid}, 32'd1);
        chk("t3_req_back", {31'd0, imem_req}, 32'd1);
        chk("t3_addr",     imem_addr,         32'h0000_300C);
        step();
        chk("t3_next_pc",  if_pc,             32'h0000_300C);

        // ---------------- 4: redirect while waiting -> DROP ----------------
        do_reset();
        step();
        step();
        imem_ready = 1'b0;
        redirect   = 1'b1;
        next_addr  = 32'h0000_3040;
        step();
        redirect   = 1'b0;
        next_addr  = 32'd0;
        chk("t4_drop_vld",  {31'd0, if_valid}, 32'd0);
        chk("t4_drop_req",  {31'd0, imem_req}, 32'd1);
        chk("t4_drop_addr", imem_addr,         32'h0000_3004);
        step();
        chk("t4_drop_addr2", imem_addr,        32'h0000_3004);
        chk("t4_drop_vld2", {31'd0, if_valid}, 32'd0);
        imem_ready = 1'b1;
        step();
        chk("t4_new_addr",  imem_addr,         32'h0000_3040);
        chk("t4_new_vld",   {31'd0, if_valid}, 32'd0);
        step();
        chk("t4_tgt_vld",   {31'd0, if_valid}, 32'd1);
        chk("t4_tgt_pc",    if_pc,             32'h0000_3040);
        chk("t4_tgt_ins",   if_ins,            32'hA5A5_3040);
        chk("t4_tgt_pc4",   if_pc_plus4,       32'h0000_3044);
        chk("t4_no_err",    {31'd0, addr_err}, 32'd0);

        // ---------------- 5: misaligned redirect ----------------
        redirect  = 1'b1;
        next_addr = 32'h0000_3042;
        step();
        redirect  = 1'b0;
        next_addr = 32'd0;
        chk("t5_err",       {31'd0, addr_err}, 32'd1);
        chk("t5_flush_vld", {31'd0, if_valid}, 32'd0);
        chk("t5_flush_ins", if_ins,            32'h0000_0000);
        chk("t5_addr",      imem_addr,         32'h0000_3040);
        step();
        chk("t5_pc",        if_pc,             32'h0000_3040);
        chk("t5_err2",      {31'd0, addr_err}, 32'd1);
        step();
        chk("t5_pc_next",   if_pc,             32'h0000_3044);
        chk("t5_err3",      {31'd0, addr_err}, 32'd1);

        // ---------------- 6: reset during DROP ----------------
        imem_ready = 1'b0;
        redirect   = 1'b1;
        next_addr  = 32'h0000_3100;
        step();
        redirect   = 1'b0;
        chk("t6_drop_req",  {31'd0, imem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_req",   {31'd0, imem_req}, 32'd0);
        chk("t6_rst_vld",   {31'd0, if_valid}, 32'd0);
        chk("t6_rst_err",   {31'd0, addr_err}, 32'd0);
        imem_ready = 1'b1;
        step();
        reset_n = 1'b1;
        chk("t6_boot_req",  {31'd0, imem_req}, 32'd0);
        step();
        chk("t6_addr",      imem_addr,         32'h0000_3000);
        chk("t6_req",       {31'd0, imem_req}, 32'd1);
        step();
        chk("t6_pc",        if_pc,             32'h0000_3000);
        chk("t6_vld",       {31'd0, if_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
